// File: rtl/terrain_bank_if.sv
// terrain_bank_if: request and pixel-query bundle for terrain_bank.
// Rects pack as {cx, cy, rx, ry} and positions as {x, y}, C_W bits per field.
interface terrain_bank_if #(
   parameter int NUM_SLOTS = 8,
   parameter int ID_W      = 8,
   parameter int HP_W      = 2,
   parameter int C_W       = 10
);
   logic                         sigSpawn;
   logic                         sigKill;
   logic                         sigHit;
   logic [ID_W-1:0]              terrainID;
   logic [4*C_W-1:0]             spawnArea;
   logic [HP_W-1:0]              spawnHP;
   logic [2*C_W-1:0]             pixelPos;
   logic                         pixelValid;
   logic [$clog2(NUM_SLOTS)-1:0] pixelSlot;
   logic [HP_W-1:0]              pixelHP;
   logic                         pixelFlash;
   logic [NUM_SLOTS-1:0]         slotValid;
   logic [$clog2(NUM_SLOTS):0]   occupancy;
   logic                         spawnDrop;

   modport master (
      output sigSpawn, sigKill, sigHit, terrainID, spawnArea, spawnHP, pixelPos,
      input  pixelValid, pixelSlot, pixelHP, pixelFlash, slotValid, occupancy, spawnDrop
   );
   modport slave (
      input  sigSpawn, sigKill, sigHit, terrainID, spawnArea, spawnHP, pixelPos,
      output pixelValid, pixelSlot, pixelHP, pixelFlash, slotValid, occupancy, spawnDrop
   );
endinterface

// File: rtl/terrain_bank.sv
// terrain_bank: fixed pool of terrain entities with spawn/kill/hit handling,
// hit/death flash countdown and a combinational per-pixel hit test.
module terrain_bank #(
   parameter int NUM_SLOTS    = 8,
   parameter int ID_W         = 8,
   parameter int HP_W         = 2,
   parameter int FLASH_FRAMES = 4,
   parameter int C_W          = 10
) (
   input logic         frameClk,
   input logic         reset_h,
   terrain_bank_if.slave bus
);
   localparam int SW = $clog2(NUM_SLOTS);
   localparam logic [1:0] S_OFF = 2'd0, S_ON = 2'd1, S_HIT = 2'd2, S_DYING = 2'd3;

   logic [1:0]       r_state [NUM_SLOTS];
   logic [ID_W-1:0]  r_id    [NUM_SLOTS];
   logic [4*C_W-1:0] r_rect  [NUM_SLOTS];
   logic [HP_W-1:0]  r_hp    [NUM_SLOTS];
   logic [3:0]       r_flash [NUM_SLOTS];
   logic [SW:0]      r_occ;
   logic             r_drop;

   logic [NUM_SLOTS-1:0] w_match, w_free, w_load, w_dmg;
   logic [SW-1:0]        w_match_idx, w_free_idx, w_tgt;
   logic                 w_spawn_ok;
   logic [1:0]           w_nstate [NUM_SLOTS];
   logic [SW:0]          w_nocc;
   logic signed [C_W:0]  w_dx, w_dy;
   logic [C_W:0]         w_ax, w_ay;

   always_comb begin
      w_match = '0;
      w_free = '0;
      w_match_idx = '0;
      w_free_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         w_match[i] = r_state[i] != S_OFF && r_id[i] == bus.terrainID;
         w_free[i] = r_state[i] == S_OFF;
         if (w_match[i]) w_match_idx = SW'(i);
         if (w_free[i]) w_free_idx = SW'(i);
      end
   end

   // kill wins over everything for the addressed ID; spawn wins over hit
   assign w_spawn_ok = bus.sigSpawn && !bus.sigKill && bus.spawnHP != '0 && (|w_match || |w_free);
   assign w_tgt = |w_match ? w_match_idx : w_free_idx;

   always_comb begin
      w_nocc = '0;
      w_load = '0;
      w_dmg = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         w_load[i] = w_spawn_ok && w_tgt == SW'(i);
         w_dmg[i] = bus.sigHit && !bus.sigKill && !bus.sigSpawn && w_match[i] &&
                    (r_state[i] == S_ON || r_state[i] == S_HIT);
         w_nstate[i] = r_state[i];
         if (bus.sigKill && w_match[i]) w_nstate[i] = S_OFF;
         else if (w_load[i]) w_nstate[i] = S_ON;
         else if (w_dmg[i]) w_nstate[i] = r_hp[i] > HP_W'(1) ? S_HIT : S_DYING;
         else if ((r_state[i] == S_HIT || r_state[i] == S_DYING) && r_flash[i] == 4'd1)
            w_nstate[i] = r_state[i] == S_HIT ? S_ON : S_OFF;
         w_nocc = w_nocc + (SW+1)'(w_nstate[i] != S_OFF);
      end
   end

   always_ff @(posedge frameClk or posedge reset_h) begin
      if (reset_h) begin
         r_occ <= '0;
         r_drop <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_state[i] <= S_OFF;
            r_id[i] <= '0;
            r_rect[i] <= '0;
            r_hp[i] <= '0;
            r_flash[i] <= '0;
         end
      end else begin
         r_occ <= w_nocc;
         r_drop <= bus.sigSpawn && !bus.sigKill && !w_spawn_ok;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_state[i] <= w_nstate[i];
            if (w_load[i]) begin
               r_id[i] <= bus.terrainID;
               r_rect[i] <= bus.spawnArea;
               r_hp[i] <= bus.spawnHP;
               r_flash[i] <= '0;
            end else if (w_dmg[i]) begin
               r_hp[i] <= r_hp[i] > HP_W'(1) ? r_hp[i] - HP_W'(1) : '0;
               r_flash[i] <= 4'(FLASH_FRAMES);
            end else if ((r_state[i] == S_HIT || r_state[i] == S_DYING) && r_flash[i] != '0) begin
               r_flash[i] <= r_flash[i] - 4'd1;
            end
         end
      end
   end

   // widened signed differences keep edge-of-screen pixels from wrapping
   always_comb begin
      bus.pixelValid = 1'b0;
      bus.pixelSlot = '0;
      bus.pixelHP = '0;
      bus.pixelFlash = 1'b0;
      bus.slotValid = '0;
      w_dx = '0;
      w_dy = '0;
      w_ax = '0;
      w_ay = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         bus.slotValid[i] = r_state[i] == S_ON || r_state[i] == S_HIT;
         w_dx = $signed({1'b0, bus.pixelPos[2*C_W-1 -: C_W]}) - $signed({1'b0, r_rect[i][4*C_W-1 -: C_W]});
         w_dy = $signed({1'b0, bus.pixelPos[C_W-1:0]}) - $signed({1'b0, r_rect[i][3*C_W-1 -: C_W]});
         w_ax = w_dx[C_W] ? -w_dx : w_dx;
         w_ay = w_dy[C_W] ? -w_dy : w_dy;
         if (r_state[i] != S_OFF && w_ax <= {1'b0, r_rect[i][2*C_W-1 -: C_W]} &&
             w_ay <= {1'b0, r_rect[i][C_W-1:0]}) begin
            bus.pixelValid = 1'b1;
            bus.pixelSlot = SW'(i);
            bus.pixelHP = r_hp[i];
            bus.pixelFlash = r_state[i] == S_HIT || r_state[i] == S_DYING;
         end
      end
   end

   assign bus.occupancy = r_occ;
   assign bus.spawnDrop = r_drop;
endmodule

// File: tb/tb_terrain_bank.sv
// tb_terrain_bank: table-driven spawn/kill/hit vectors with a spawnDrop
// scoreboard, plus hand sequences for flash countdown, priority and reset.
module tb_terrain_bank;
   logic frameClk = 1'b0;
   logic reset_h = 1'b1;
   int   total = 0;
   int   bad = 0;
   bit   drop_q [$];

   typedef struct {
      logic [2:0] op;
      int id, cx, cy, rx, ry, hp;
      bit drop;
      int occ;
   } vec_t;
   vec_t tbl [15];

   terrain_bank_if #(.NUM_SLOTS(8), .ID_W(8), .HP_W(2), .C_W(10)) bus ();
   terrain_bank #(.NUM_SLOTS(8), .ID_W(8), .HP_W(2), .FLASH_FRAMES(4), .C_W(10)) dut (
      .frameClk(frameClk),
      .reset_h(reset_h),
      .bus(bus)
   );

   always #5 frameClk = ~frameClk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic [2:0] op, input int id, input int cx, input int cy,
                       input int rx, input int ry, input int hp, input bit exp_drop);
      bus.sigKill = op[2];
      bus.sigSpawn = op[1];
      bus.sigHit = op[0];
      bus.terrainID = 8'(id);
      bus.spawnArea = {10'(cx), 10'(cy), 10'(rx), 10'(ry)};
      bus.spawnHP = 2'(hp);
      drop_q.push_back(exp_drop);
      @(posedge frameClk);
      #1;
      {bus.sigKill, bus.sigSpawn, bus.sigHit} = 3'b000;
      check("spawnDrop", int'(bus.spawnDrop), int'(drop_q.pop_front()));
   endtask

   task automatic idle();
      step(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
   endtask

   task automatic pix(input string name, input int x, input int y, input int v, input int s, input int hp);
      bus.pixelPos = {10'(x), 10'(y)};
      #1;
      check({name, ".valid"}, int'(bus.pixelValid), v);
      check({name, ".slot"}, int'(bus.pixelSlot), s);
      check({name, ".hp"}, int'(bus.pixelHP), hp);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8; i++) tbl[i] = '{3'b010, i, 200 + 20 * i, 300, 2, 2, 3, 1'b0, i + 1};
      tbl[8]  = '{3'b010, 9, 500, 500, 2, 2, 3, 1'b1, 8};
      tbl[9]  = '{3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 8};
      tbl[10] = '{3'b010, 3, 400, 400, 5, 5, 1, 1'b0, 8};
      tbl[11] = '{3'b111, 5, 600, 600, 2, 2, 2, 1'b0, 7};
      tbl[12] = '{3'b010, 20, 600, 600, 2, 2, 0, 1'b1, 7};
      tbl[13] = '{3'b001, 99, 0, 0, 0, 0, 0, 1'b0, 7};
      tbl[14] = '{3'b100, 99, 0, 0, 0, 0, 0, 1'b0, 7};
      {bus.sigKill, bus.sigSpawn, bus.sigHit} = 3'b000;
      bus.terrainID = '0;
      bus.spawnArea = '0;
      bus.spawnHP = '0;
      bus.pixelPos = '0;
      #2;
      check("rst.occ", int'(bus.occupancy), 0);
      check("rst.slotValid", int'(bus.slotValid), 0);
      check("rst.drop", int'(bus.spawnDrop), 0);
      check("rst.pixValid", int'(bus.pixelValid), 0);
      @(posedge frameClk);
      #1;
      reset_h = 1'b0;

      // basic spawn and inclusive pixel test
      step(3'b010, 5, 100, 100, 8, 8, 2, 1'b0);
      check("spawn.occ", int'(bus.occupancy), 1);
      pix("p108_92", 108, 92, 1, 0, 2);
      pix("p109_100", 109, 100, 0, 0, 0);
      pix("p92_108", 92, 108, 1, 0, 2);
      pix("p100_91", 100, 91, 0, 0, 0);

      // hit -> HIT for 4 edges -> ON; second hit -> DYING -> OFF
      step(3'b001, 5, 0, 0, 0, 0, 0, 1'b0);
      pix("hit", 100, 100, 1, 0, 1);
      check("hit.flash", int'(bus.pixelFlash), 1);
      for (int k = 0; k < 3; k++) begin
         idle();
         check("hit.flashHold", int'(bus.pixelFlash), 1);
      end
      idle();
      check("hit.flashEnd", int'(bus.pixelFlash), 0);
      check("hit.backOn", int'(bus.slotValid[0]), 1);
      step(3'b001, 5, 0, 0, 0, 0, 0, 1'b0);
      check("dying.slotValid", int'(bus.slotValid[0]), 0);
      pix("dying", 100, 100, 1, 0, 0);
      check("dying.flash", int'(bus.pixelFlash), 1);
      for (int k = 0; k < 3; k++) begin
         idle();
         check("dying.occHold", int'(bus.occupancy), 1);
      end
      idle();
      check("dying.occEnd", int'(bus.occupancy), 0);
      pix("dead", 100, 100, 0, 0, 0);

      // table: fill, overflow, respawn, priority, zero HP, unmatched IDs
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].op, tbl[i].id, tbl[i].cx, tbl[i].cy, tbl[i].rx, tbl[i].ry, tbl[i].hp, tbl[i].drop);
         check($sformatf("tbl%0d.occ", i), int'(bus.occupancy), tbl[i].occ);
      end
      check("tbl.slotValid", int'(bus.slotValid), 8'hDF);
      pix("respawn3", 400, 400, 1, 3, 1);
      pix("old3", 260, 300, 0, 0, 0);
      pix("slot1", 220, 302, 1, 1, 3);
      pix("killed5", 300, 300, 0, 0, 0);

      // overlap priority and screen-edge wrap
      @(negedge frameClk);
      reset_h = 1'b1;
      #1;
      check("rst2.occ", int'(bus.occupancy), 0);
      reset_h = 1'b0;
      step(3'b010, 10, 600, 600, 1, 1, 2, 1'b0);
      step(3'b010, 11, 48, 52, 3, 3, 2, 1'b0);
      step(3'b010, 12, 700, 100, 1, 1, 2, 1'b0);
      step(3'b010, 13, 700, 200, 1, 1, 2, 1'b0);
      step(3'b010, 14, 50, 50, 0, 0, 2, 1'b0);
      step(3'b010, 15, 1020, 1020, 5, 5, 2, 1'b0);
      check("ovl.occ", int'(bus.occupancy), 6);
      pix("ovl", 50, 50, 1, 1, 2);
      pix("wrap", 3, 3, 0, 0, 0);
      pix("edge", 1023, 1015, 1, 5, 2);
      step(3'b100, 11, 0, 0, 0, 0, 0, 1'b0);
      pix("ovlKill", 50, 50, 1, 4, 2);
      check("ovlKill.occ", int'(bus.occupancy), 5);

      // reset in the middle of a death countdown
      step(3'b010, 7, 50, 50, 4, 4, 1, 1'b0);
      step(3'b001, 7, 0, 0, 0, 0, 0, 1'b0);
      pix("die7", 50, 50, 1, 1, 0);
      check("die7.slotValid", int'(bus.slotValid[1]), 0);
      idle();
      reset_h = 1'b1;
      #1;
      check("midRst.slotValid", int'(bus.slotValid), 0);
      check("midRst.occ", int'(bus.occupancy), 0);
      check("midRst.pixValid", int'(bus.pixelValid), 0);
      #1;
      reset_h = 1'b0;
      step(3'b010, 33, 50, 50, 1, 1, 2, 1'b0);
      pix("postRst", 50, 50, 1, 0, 2);
      check("postRst.occ", int'(bus.occupancy), 1);
      for (int k = 0; k < 4; k++) idle();
      check("postRst.stable", int'(bus.slotValid), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/terrain_bank.md
TERRAIN_BANK -- requirements
Module: terrain_bank

Interface
REQ-001 Parameter NUM_SLOTS, default 8: number of terrain entity slots; legal range 2-32.
REQ-002 Parameter ID_W, default 8: width of terrainID.
REQ-003 Parameter HP_W, default 2: width of hit-point fields.
REQ-004 Parameter FLASH_FRAMES, default 4: frames a slot flashes after a hit or during death; legal range 1-15.
REQ-005 Port frameClk  in  1: the single clock; all state updates on its rising edge.
REQ-006 Port reset_h  in  1: asynchronous, active-high reset.
REQ-007 Port sigSpawn  in  1: spawn request, sampled each frameClk edge.
REQ-008 Port sigKill  in  1: kill request for terrainID.
REQ-009 Port sigHit  in  1: damage request for terrainID.
REQ-010 Port terrainID  in  ID_W: ID targeted by spawn, kill or hit.
REQ-011 Port spawnArea  in  RECT: center and radius loaded on spawn.
REQ-012 Port spawnHP  in  HP_W: initial hit points on spawn.
REQ-013 Port pixelPos  in  POSITION: pixel being drawn.
REQ-014 Port pixelValid  out  1: pixelPos lies inside a live slot.
REQ-015 Port pixelSlot  out  $clog2(NUM_SLOTS): index of the matching slot.
REQ-016 Port pixelHP  out  HP_W: HP of the matching slot.
REQ-017 Port pixelFlash  out  1: the matching slot is in state HIT or DYING.
REQ-018 Port slotValid  out  NUM_SLOTS: per-slot live flag, set for states ON and HIT only.
REQ-019 Port occupancy  out  $clog2(NUM_SLOTS)+1: count of slots not OFF.
REQ-020 Port spawnDrop  out  1: one-cycle pulse when a spawn is rejected.

Function
REQ-021 Each slot SHALL hold a state (OFF, ON, HIT, DYING), an ID, a RECT, an HP value and a 4-bit flash counter.
REQ-022 A spawn SHALL load spawnArea, spawnHP and terrainID into the slot already holding terrainID in any non-OFF state (respawn); otherwise into the lowest-index OFF slot. The loaded slot enters ON and its flash counter clears.
REQ-023 A spawn SHALL be rejected and spawnDrop SHALL pulse on the next edge if spawnHP==0, or if no slot holds terrainID and no slot is OFF.
REQ-024 A kill SHALL move the slot holding terrainID to OFF on the next edge from any state; with no matching slot it is ignored.
REQ-025 Priority for one ID in one cycle SHALL be kill > spawn > hit; the losing requests are discarded and do not raise spawnDrop.
REQ-026 A hit on an ON or HIT slot with HP>1 SHALL decrement HP, enter HIT and load the flash counter with FLASH_FRAMES. A hit during HIT restarts the count.
REQ-027 A hit on an ON or HIT slot with HP==1 SHALL set HP to 0, enter DYING and load FLASH_FRAMES.
REQ-028 Hits on DYING or OFF slots, or on unmatched IDs, SHALL be ignored.
REQ-029 In HIT and DYING, the flash counter SHALL decrement once per edge. The edge on which it goes 1->0 SHALL move HIT to ON and DYING to OFF.
REQ-030 ID matching SHALL compare full ID_W bits. At most one non-OFF slot ever holds a given ID.
REQ-031 The pixel test SHALL be inclusive: |x-cx|<=rx and |y-cy|<=ry. It SHALL use one-bit-wider signed differences so no wrap occurs at the screen edges.
REQ-032 The pixel outputs SHALL be combinational from slot state and pixelPos. They cover HIT, ON and DYING slots; the lowest matching index wins; with no match all pixel outputs are 0.
REQ-033 occupancy SHALL be registered and reflect state after each edge.

Reset
REQ-034 Asserting reset_h SHALL immediately force all slots to OFF with ID, RECT, HP and flash counter 0, occupancy 0 and spawnDrop 0, regardless of frameClk or pending requests.
REQ-035 During reset all requests SHALL be ignored. The first edge after deassertion SHALL process requests normally, including when reset interrupts a HIT or DYING countdown.

Verification
REQ-036 Spawn ID 5 with area {center {100,100}, radius {8,8}} and HP 2, then pixelPos {108,92} -> pixelValid=1, pixelSlot=0, pixelHP=2; pixelPos {109,100} -> pixelValid=0; occupancy=1.
REQ-037 Fill 8 slots with IDs 0-7, then spawn ID 9 -> spawnDrop pulses for one cycle and occupancy stays 8. Then spawn ID 3 with a new area -> slot 3 updated and no spawnDrop.
REQ-038 ID 5 with HP 2, FLASH_FRAMES 4: hit -> HIT, HP 1, pixelFlash=1 for 4 edges, then ON. Second hit -> DYING, slotValid=0, pixelValid still 1; after 4 edges the slot is OFF and occupancy drops by 1.
REQ-039 Same-cycle sigKill, sigSpawn and sigHit on live ID 5 -> slot goes OFF and spawnDrop=0. Spawn with spawnHP=0 -> spawnDrop pulses and no slot changes.
REQ-040 Overlapping slots 1 and 4 cover pixel {50,50} -> pixelSlot=1. Kill the ID in slot 1 -> pixelSlot=4.
REQ-041 Assert reset_h mid-DYING, between clock edges -> slotValid, occupancy and pixelValid go to 0 without a clock edge. After release, a spawn lands in slot 0.
